tpu_sched: RTL

Sequencer for a DIM×DIM systolic array of floating-point MAC cells. On `start`, it optionally preloads the accumulators row by row, then drives the common compute enable for the skewed operand stream plus pipeline drain. It also emits per-lane operand-valid masks and step indices that the A/B operand buffers use to present skewed data. It sits between the host command interface and the MAC array; it owns every MAC `en`/`WrEn` line.

---
 rtl/tpu_sched_pkg.sv | 24 ++
 rtl/tpu_skew_mask.sv | 41 ++++
 rtl/tpu_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tpu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_sched_pkg
// Description : Shared types and helpers for the systolic-array sequencer.
//               Holds the FSM state encoding and the pipeline drain length
//               helper (2*DIM-2 cycles for the skewed operand wavefront).
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADC   = 2'd1,
    COMPUTE = 2'd2,
    FIN     = 2'd3
  } tpu_sched_state_t;

  // Extra compute cycles needed for the skewed wavefront to cross the array.
  function automatic int drain_len(input int dim);
    return 2 * dim - 2;
  endfunction

endpackage : tpu_sched_pkg
`default_nettype wire

// File: rtl/tpu_skew_mask.sv
`default_nettype none
// ============================================================================
// Module      : tpu_skew_mask
// Description : Combinational per-lane operand-valid mask. Lane i carries real
//               data while step lies in [i, i + k_len).
// Ports       : step_i     - current compute step
//               k_len_i    - latched inner dimension
//               active_i   - high only in an unstalled compute cycle
//               lane_vld_o - per-lane valid mask
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_skew_mask #(
  parameter int DIM = 8,
  parameter int KW  = 8,
  parameter int SW  = KW + $clog2(DIM) + 1
) (
  input  logic [SW-1:0]  step_i,
  input  logic [KW-1:0]  k_len_i,
  input  logic           active_i,
  output logic [DIM-1:0] lane_vld_o
);

  // One spare bit so i + k_len never wraps.
  localparam int PW = SW + 1;

  logic [PW-1:0] w_step;
  logic [PW-1:0] w_klen;

  assign w_step = {1'b0, step_i};
  assign w_klen = PW'(k_len_i);

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_lane
      localparam logic [PW-1:0] C_LO = PW'(gi);
      assign lane_vld_o[gi] = active_i && (w_step >= C_LO) && (w_step < (C_LO + w_klen));
    end
  endgenerate

endmodule : tpu_skew_mask
`default_nettype wire

// File: rtl/tpu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tpu_sched
// Description : Sequencer for a DIM x DIM systolic MAC array. On an accepted
//               start it optionally preloads accumulators row by row, then
//               drives the common MAC enable for k_len + 2*DIM - 2 steps,
//               then pulses done for one cycle.
// Ports       : clk_i, rst_ni        - clock, async active-low reset
//               start_i, load_c_i    - command strobe / preload request
//               k_len_i              - inner dimension (latched on accept)
//               hold_i               - stall of the active phases
//               busy_o, done_o       - status
//               mac_en_o, c_wr_en_o  - MAC enable / per-row preload write
//               c_row_o, step_o      - preload row / compute step indices
//               lane_vld_o           - per-lane operand-valid mask
//               perf_active_o, perf_stall_o - only with TPU_SCHED_PERF_EN
// Config      : `define TPU_SCHED_PERF_EN adds saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_sched
  import tpu_sched_pkg::*;
#(
  parameter int DIM = 8,
  parameter int KW  = 8,
  parameter int SW  = KW + $clog2(DIM) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    load_c_i,
  input  logic [KW-1:0]           k_len_i,
  input  logic                    hold_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    mac_en_o,
  output logic [DIM-1:0]          c_wr_en_o,
  output logic [$clog2(DIM)-1:0]  c_row_o,
  output logic [SW-1:0]           step_o,
  output logic [DIM-1:0]          lane_vld_o
`ifdef TPU_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_active_o,
  output logic [31:0]             perf_stall_o
`endif
);

  localparam int              CW      = $clog2(DIM);
  localparam logic [SW-1:0]   C_DRAIN = SW'(drain_len(DIM));
  localparam logic [SW-1:0]   C_LROW  = SW'(DIM - 1);

  tpu_sched_state_t state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_len_q, k_len_d;

  logic             w_load_last;
  logic             w_comp_last;
  logic             w_accept;
  logic             w_active;

  // Last compute step index is k_len + 2*DIM - 3; only evaluated with k_len != 0.
  assign w_load_last = (cnt_q == C_LROW);
  assign w_comp_last = (cnt_q == (SW'(k_len_q) + C_DRAIN - SW'(1)));
  assign w_accept    = (state_q == IDLE) && start_i;
  assign w_active    = (state_q == COMPUTE) && !hold_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_len_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_len_q <= k_len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_len_d   = k_len_q;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    mac_en_o  = 1'b0;
    c_wr_en_o = '0;
    c_row_o   = '0;
    step_o    = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          k_len_d = k_len_i;
          cnt_d   = '0;
          if (load_c_i)           state_d = LOADC;
          else if (k_len_i != '0) state_d = COMPUTE;
          else                    state_d = FIN;
        end
      end

      LOADC: begin
        busy_o  = 1'b1;
        c_row_o = cnt_q[CW-1:0];
        if (!hold_i) begin
          c_wr_en_o = DIM'(1) << cnt_q[CW-1:0];
          if (w_load_last) begin
            cnt_d   = '0;
            state_d = (k_len_q != '0) ? COMPUTE : FIN;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
      end

      COMPUTE: begin
        busy_o = 1'b1;
        step_o = cnt_q;
        if (!hold_i) begin
          mac_en_o = 1'b1;
          if (w_comp_last) begin
            cnt_d   = '0;
            state_d = FIN;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
      end

      FIN: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  tpu_skew_mask #(
    .DIM (DIM),
    .KW  (KW),
    .SW  (SW)
  ) u_skew_mask (
    .step_i     (cnt_q),
    .k_len_i    (k_len_q),
    .active_i   (w_active),
    .lane_vld_o (lane_vld_o)
  );

`ifdef TPU_SCHED_PERF_EN
  logic [31:0] perf_active_q;
  logic [31:0] perf_stall_q;

  // Clear on accept takes priority; both counters stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_active_q <= '0;
      perf_stall_q  <= '0;
    end else if (w_accept) begin
      perf_active_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (mac_en_o && (perf_active_q != '1))
        perf_active_q <= perf_active_q + 32'd1;
      if (busy_o && hold_i && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_active_o = perf_active_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule : tpu_sched
`default_nettype wire
